// File: rtl/dram_march_bist.sv
// Distributed LUT RAM (sync write, async read) with a March C- self-test sequencer
// and an external access port that owns the RAM whenever the sequencer is idle.
module dram_march_bist #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_d,
    output logic [DATA_W-1:0] ext_q,
    input  logic              flt_en,
    input  logic [ADDR_W-1:0] flt_addr
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_LO = '0;
    localparam logic [ADDR_W-1:0] ADDR_HI = '1;
    localparam logic [DATA_W-1:0] WORD_Z  = '0;
    localparam logic [DATA_W-1:0] WORD_O  = '1;

    typedef enum logic [2:0] {
        st_idle, st_m0, st_m1, st_m2, st_m3, st_m4, st_m5, st_done
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                pass_q, pass_d;
    logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [DATA_W-1:0]   rd_word;
    logic [DATA_W-1:0]   flt_mask;
    logic                rd_en, wr_en, is_up, last, miscmp;
    logic [DATA_W-1:0]   exp_word, wr_word;
    state_t              nxt_state;
    logic [ADDR_W-1:0]   nxt_addr;

    logic                ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_d;

    assign busy      = (state_q != st_idle) && (state_q != st_done);
    assign done      = (state_q == st_done);
    assign pass      = pass_q;
    assign fail_addr = fail_addr_q;

    // Fault injection only disturbs what the comparator sees, never the array.
    assign flt_mask = (flt_en && (flt_addr == addr_q)) ? DATA_W'(1) : WORD_Z;
    assign rd_word  = mem[addr_q] ^ flt_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= st_idle;
            addr_q      <= '0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        rd_en       = 1'b0;
        wr_en       = 1'b0;
        is_up       = 1'b1;
        exp_word    = WORD_Z;
        wr_word     = WORD_Z;
        nxt_state   = state_q;
        nxt_addr    = ADDR_LO;
        miscmp      = 1'b0;
        last        = 1'b0;

        case (state_q)
            st_idle: begin
                if (start) begin
                    state_d     = st_m0;
                    addr_d      = ADDR_LO;
                    pass_d      = 1'b0;
                    fail_addr_d = '0;
                end
            end
            st_m0: begin
                wr_en = 1'b1; wr_word = WORD_Z;
                nxt_state = st_m1; nxt_addr = ADDR_LO;
            end
            st_m1: begin
                rd_en = 1'b1; exp_word = WORD_Z; wr_en = 1'b1; wr_word = WORD_O;
                nxt_state = st_m2; nxt_addr = ADDR_LO;
            end
            st_m2: begin
                rd_en = 1'b1; exp_word = WORD_O; wr_en = 1'b1; wr_word = WORD_Z;
                nxt_state = st_m3; nxt_addr = ADDR_HI;
            end
            st_m3: begin
                is_up = 1'b0;
                rd_en = 1'b1; exp_word = WORD_Z; wr_en = 1'b1; wr_word = WORD_O;
                nxt_state = st_m4; nxt_addr = ADDR_HI;
            end
            st_m4: begin
                is_up = 1'b0;
                rd_en = 1'b1; exp_word = WORD_O; wr_en = 1'b1; wr_word = WORD_Z;
                nxt_state = st_m5; nxt_addr = ADDR_LO;
            end
            st_m5: begin
                rd_en = 1'b1; exp_word = WORD_Z;
                nxt_state = st_done; nxt_addr = ADDR_LO;
            end
            st_done: begin
                state_d = st_idle;
            end
            default: begin
                state_d = st_idle;
            end
        endcase

        if (busy) begin
            miscmp = rd_en && (rd_word != exp_word);
            last   = is_up ? (addr_q == ADDR_HI) : (addr_q == ADDR_LO);
            if (miscmp) begin
                state_d     = st_done;
                fail_addr_d = addr_q;
                pass_d      = 1'b0;
            end else if (last) begin
                // Element boundary: jump straight to the next element's start address.
                state_d = nxt_state;
                addr_d  = nxt_addr;
                if (nxt_state == st_done) pass_d = 1'b1;
            end else begin
                addr_d = is_up ? (addr_q + ADDR_W'(1)) : (addr_q - ADDR_W'(1));
            end
        end
    end

    // The external port is cut off entirely while the sequencer owns the array.
    assign ram_we   = busy ? (wr_en && !miscmp) : ext_we;
    assign ram_addr = busy ? addr_q : ext_addr;
    assign ram_d    = busy ? wr_word : ext_d;

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_d;
    end

    assign ext_q = busy ? WORD_Z : mem[ext_addr];

endmodule
